dmem_arbiter: RTL

- Shares the single-port data RAM between two requesters.
  - Port 0: pipeline CPU data port.
  - Port 1: debug/DMA master, e.g. a UART loader or memory inspector.
- Fixed priority goes to the CPU. A starvation guard and a lock mode guarantee port-1 progress.
- Sits between the CPU/debug masters and the data RAM in the SoC top. It drives the RAM's write-enable, word address and write data. The RAM is clocked on the inverted clock.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_starve_ctr.sv | 24 ++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-RAM arbiter
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        FORCE1 = 2'd1,
        LOCK1  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - saturating count of consecutive port-1 denials
module dmem_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt,
    output logic       hit
);

    // hit flags the denial that brings the count up to MAX_WAIT
    assign hit = inc && (cnt >= 4'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt < 4'(MAX_WAIT))) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority arbiter for the single-port data RAM
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t        state, state_next;
    owner_t            rd_owner;
    logic              g0, g1;
    logic              ctr_clr, ctr_inc, ctr_hit;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] sel_addr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                                m1_addr[31:ADDR_W+2], m1_addr[1:0], wait_cnt};

    dmem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .inc (ctr_inc),
        .cnt (wait_cnt),
        .hit (ctr_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        g0         = 1'b0;
        g1         = 1'b0;
        ctr_clr    = 1'b0;
        ctr_inc    = 1'b0;
        case (state)
            ARB: begin
                if (m0_req) begin
                    g0 = 1'b1;
                    if (m1_req) begin
                        ctr_inc = 1'b1;
                        if (ctr_hit) begin
                            state_next = FORCE1;
                        end
                    end else begin
                        ctr_clr = 1'b1;
                    end
                end else if (m1_req) begin
                    g1      = 1'b1;
                    ctr_clr = 1'b1;
                    if (m1_lock) begin
                        state_next = LOCK1;
                    end
                end else begin
                    ctr_clr = 1'b1;
                end
            end
            FORCE1: begin
                ctr_clr = 1'b1;
                if (m1_req) begin
                    g1         = 1'b1;
                    state_next = m1_lock ? LOCK1 : ARB;
                end else begin
                    state_next = ARB;
                end
            end
            LOCK1: begin
                // port 1 owns the RAM; the cycle m1_lock drops is still port-1-only
                g1      = m1_req;
                ctr_clr = 1'b1;
                if (!m1_lock) begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next = ARB;
                ctr_clr    = 1'b1;
            end
        endcase
    end

    // reset masks grants and pending read-valids immediately
    assign m0_gnt    = g0 & ~rst;
    assign m1_gnt    = g1 & ~rst;
    assign m0_rvalid = (rd_owner == OWN_M0) & ~rst;
    assign m1_rvalid = (rd_owner == OWN_M1) & ~rst;

    assign sel_addr = g1 ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
    assign ram_addr = (m0_gnt || m1_gnt) ? sel_addr : last_addr;
    assign ram_we   = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    assign ram_din  = g1 ? m1_wdata : m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner  <= OWN_NONE;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            last_addr <= '0;
        end else begin
            last_addr <= ram_addr;
            if (m0_gnt && !m0_we) begin
                rd_owner <= OWN_M0;
                m0_rdata <= ram_dout;
            end else if (m1_gnt && !m1_we) begin
                rd_owner <= OWN_M1;
                m1_rdata <= ram_dout;
            end else begin
                rd_owner <= OWN_NONE;
            end
        end
    end

endmodule
